// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace queue: one retired-instruction record and its field widths.
package commit_trace_pkg;

  localparam int XLEN   = 64;
  localparam int INSN_W = 32;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INSN_W-1:0] insn;
    logic              rd_valid;
    logic              rd_fp;
    logic [REG_W-1:0]  rd_addr;
    logic [XLEN-1:0]   rd_data;
    logic              exc_valid;
    logic [XLEN-1:0]   exc_cause;
  } commit_rec_t;

  localparam int REC_W = $bits(commit_rec_t);

endpackage

// File: rtl/commit_slot_compactor.sv
// Per-slot rank among the valid retirement slots (prefix popcount) plus the total valid count.
module commit_slot_compactor #(
  parameter int COMMITS = 2,
  parameter int CNT_W   = 2
) (
  input  logic [COMMITS-1:0]       valid_i,
  output logic [COMMITS*CNT_W-1:0] offset_o,
  output logic [CNT_W-1:0]         total_o
);

  always_comb begin
    logic [CNT_W-1:0] acc;
    acc      = '0;
    offset_o = '0;
    for (int i = 0; i < COMMITS; i++) begin
      offset_o[i*CNT_W +: CNT_W] = acc;
      acc = acc + CNT_W'(valid_i[i]);
    end
    total_o = acc;
  end

endmodule

// File: rtl/commit_trace_queue.sv
// Multi-wide commit capture FIFO presenting one record per handshake to the cosim checker.
// Optional hang watchdog is built when COMMIT_TRACE_WATCHDOG_EN is defined.
module commit_trace_queue
  import commit_trace_pkg::*;
#(
  parameter int COMMITS = 2,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 100000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [COMMITS-1:0]        in_valid,
  input  logic [64*COMMITS-1:0]     in_pc,
  input  logic [32*COMMITS-1:0]     in_insn,
  input  logic [COMMITS-1:0]        in_rd_valid,
  input  logic [COMMITS-1:0]        in_rd_fp,
  input  logic [5*COMMITS-1:0]      in_rd_addr,
  input  logic [64*COMMITS-1:0]     in_rd_data,
  input  logic [COMMITS-1:0]        in_exc_valid,
  input  logic [64*COMMITS-1:0]     in_exc_cause,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [63:0]               out_pc,
  output logic [31:0]               out_insn,
  output logic                      out_rd_valid,
  output logic                      out_rd_fp,
  output logic [4:0]                out_rd_addr,
  output logic [63:0]               out_rd_data,
  output logic                      out_exc_valid,
  output logic [63:0]               out_exc_cause,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      overflow,
  output logic                      hang
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = $clog2(COMMITS + 1);

  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]         occ_q, occ_d;
  logic                     overflow_q, overflow_d;
  logic [REC_W-1:0]         mem_q [DEPTH];

  logic [COMMITS*CNT_W-1:0] offsets;
  logic [CNT_W-1:0]         n;
  logic [OCC_W-1:0]         free, n_ext, written;
  logic                     pop;
  logic [COMMITS-1:0]       wr_en;
  logic [PTR_W-1:0]         wr_idx   [COMMITS];
  commit_rec_t              slot_rec [COMMITS];
  commit_rec_t              head;

  commit_slot_compactor #(
    .COMMITS (COMMITS),
    .CNT_W   (CNT_W)
  ) u_compactor (
    .valid_i  (in_valid),
    .offset_o (offsets),
    .total_o  (n)
  );

  // Space is judged on the occupancy at cycle start; a same-cycle pop frees nothing.
  always_comb begin
    free    = OCC_W'(DEPTH) - occ_q;
    n_ext   = OCC_W'(n);
    written = (n_ext > free) ? free : n_ext;
    pop     = out_valid && out_ready;
    wr_en   = '0;
    for (int i = 0; i < COMMITS; i++) begin
      slot_rec[i].pc        = in_pc[64*i +: 64];
      slot_rec[i].insn      = in_insn[32*i +: 32];
      slot_rec[i].rd_valid  = in_rd_valid[i];
      slot_rec[i].rd_fp     = in_rd_fp[i];
      slot_rec[i].rd_addr   = in_rd_addr[5*i +: 5];
      slot_rec[i].rd_data   = in_rd_data[64*i +: 64];
      slot_rec[i].exc_valid = in_exc_valid[i];
      slot_rec[i].exc_cause = in_exc_cause[64*i +: 64];
      wr_en[i]  = in_valid[i] && (OCC_W'(offsets[i*CNT_W +: CNT_W]) < free);
      wr_idx[i] = wr_ptr_q + PTR_W'(offsets[i*CNT_W +: CNT_W]);
    end
    occ_d      = occ_q + written - OCC_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(written);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    overflow_d = overflow_q | (n_ext > free);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < COMMITS; i++) begin
      if (wr_en[i]) mem_q[wr_idx[i]] <= slot_rec[i];
    end
  end

  assign head          = commit_rec_t'(mem_q[rd_ptr_q]);
  assign out_valid     = (occ_q != '0);
  assign out_pc        = head.pc;
  assign out_insn      = head.insn;
  assign out_rd_valid  = head.rd_valid;
  assign out_rd_fp     = head.rd_fp;
  assign out_rd_addr   = head.rd_addr;
  assign out_rd_data   = head.rd_data;
  assign out_exc_valid = head.exc_valid;
  assign out_exc_cause = head.exc_cause;
  assign in_ready      = (free >= OCC_W'(COMMITS));
  assign occupancy     = occ_q;
  assign overflow      = overflow_q;

`ifdef COMMIT_TRACE_WATCHDOG_EN
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        hang_q, hang_d;

  // Counter saturates at TIMEOUT so the flag cannot be lost to wraparound.
  always_comb begin
    if (n != '0)                        wd_cnt_d = '0;
    else if (wd_cnt_q != 32'(TIMEOUT))  wd_cnt_d = wd_cnt_q + 32'd1;
    else                                wd_cnt_d = wd_cnt_q;
    hang_d = hang_q | (wd_cnt_d == 32'(TIMEOUT));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt_q <= '0;
      hang_q   <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      hang_q   <= hang_d;
    end
  end

  assign hang = hang_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign hang = 1'b0;
`endif

endmodule

// File: tb/tb_commit_trace_queue.sv
// Self-checking bench for commit_trace_queue against a queue-based reference model.
module tb_commit_trace_queue;

  localparam int COMMITS = 2;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 50;
`ifdef COMMIT_TRACE_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [COMMITS-1:0]    in_valid;
  logic [64*COMMITS-1:0] in_pc;
  logic [32*COMMITS-1:0] in_insn;
  logic [COMMITS-1:0]    in_rd_valid;
  logic [COMMITS-1:0]    in_rd_fp;
  logic [5*COMMITS-1:0]  in_rd_addr;
  logic [64*COMMITS-1:0] in_rd_data;
  logic [COMMITS-1:0]    in_exc_valid;
  logic [64*COMMITS-1:0] in_exc_cause;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [63:0]           out_pc;
  logic [31:0]           out_insn;
  logic                  out_rd_valid;
  logic                  out_rd_fp;
  logic [4:0]            out_rd_addr;
  logic [63:0]           out_rd_data;
  logic                  out_exc_valid;
  logic [63:0]           out_exc_cause;
  logic [4:0]            occupancy;
  logic                  overflow;
  logic                  hang;

  commit_trace_queue #(.COMMITS(COMMITS), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_insn(in_insn),
    .in_rd_valid(in_rd_valid), .in_rd_fp(in_rd_fp), .in_rd_addr(in_rd_addr),
    .in_rd_data(in_rd_data), .in_exc_valid(in_exc_valid), .in_exc_cause(in_exc_cause),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_insn(out_insn), .out_rd_valid(out_rd_valid),
    .out_rd_fp(out_rd_fp), .out_rd_addr(out_rd_addr), .out_rd_data(out_rd_data),
    .out_exc_valid(out_exc_valid), .out_exc_cause(out_exc_cause),
    .occupancy(occupancy), .overflow(overflow), .hang(hang)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] insn;
    logic        rd_valid;
    logic        rd_fp;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
    logic        exc_valid;
    logic [63:0] exc_cause;
  } rec_t;

  rec_t mq[$];
  bit   m_ovf;
  bit   m_hang;
  int   m_idle;
  int   passed = 0;
  int   total  = 0;

  function automatic rec_t rand_rec();
    rec_t r;
    r.pc        = {$urandom, $urandom};
    r.insn      = $urandom;
    r.rd_valid  = 1'($urandom);
    r.rd_fp     = 1'($urandom);
    r.rd_addr   = 5'($urandom);
    r.rd_data   = {$urandom, $urandom};
    r.exc_valid = 1'($urandom);
    r.exc_cause = {$urandom, $urandom};
    return r;
  endfunction

  function automatic rec_t slot_rec(int s);
    rec_t r;
    r.pc        = in_pc[64*s +: 64];
    r.insn      = in_insn[32*s +: 32];
    r.rd_valid  = in_rd_valid[s];
    r.rd_fp     = in_rd_fp[s];
    r.rd_addr   = in_rd_addr[5*s +: 5];
    r.rd_data   = in_rd_data[64*s +: 64];
    r.exc_valid = in_exc_valid[s];
    r.exc_cause = in_exc_cause[64*s +: 64];
    return r;
  endfunction

  function automatic rec_t dut_head();
    return {out_pc, out_insn, out_rd_valid, out_rd_fp, out_rd_addr,
            out_rd_data, out_exc_valid, out_exc_cause};
  endfunction

  task automatic set_slot(int s, rec_t r);
    in_valid[s]             = 1'b1;
    in_pc[64*s +: 64]       = r.pc;
    in_insn[32*s +: 32]     = r.insn;
    in_rd_valid[s]          = r.rd_valid;
    in_rd_fp[s]             = r.rd_fp;
    in_rd_addr[5*s +: 5]    = r.rd_addr;
    in_rd_data[64*s +: 64]  = r.rd_data;
    in_exc_valid[s]         = r.exc_valid;
    in_exc_cause[64*s +: 64] = r.exc_cause;
  endtask

  task automatic clear_inputs();
    in_valid = '0; in_pc = '0; in_insn = '0; in_rd_valid = '0; in_rd_fp = '0;
    in_rd_addr = '0; in_rd_data = '0; in_exc_valid = '0; in_exc_cause = '0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0; m_hang = 1'b0; m_idle = 0;
  endtask

  // Advance the reference model by one cycle using the inputs as presented, then cross the edge.
  task automatic tick();
    int   free, n;
    bit   pop;
    rec_t nw[$];
    pop  = (mq.size() != 0) && out_ready;
    free = DEPTH - mq.size();
    n    = 0;
    for (int s = 0; s < COMMITS; s++) begin
      if (in_valid[s]) begin
        n++;
        if (nw.size() < free) nw.push_back(slot_rec(s));
      end
    end
    if (n > free) m_ovf = 1'b1;
    if (pop) void'(mq.pop_front());
    foreach (nw[k]) mq.push_back(nw[k]);
    if (n > 0) m_idle = 0;
    else if (m_idle < TIMEOUT) m_idle++;
    if (WD_ON && m_idle == TIMEOUT) m_hang = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #3;
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    out_ready = 1'b0;
    reset = 1'b0;
    model_reset();
    #12;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b expected 0", out_valid); else passed++;
    total++; if (occupancy !== 5'd0) $display("FAIL reset_occupancy: got %0d expected 0", occupancy); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %0b expected 0", overflow); else passed++;
    total++; if (hang !== 1'b0) $display("FAIL reset_hang: got %0b expected 0", hang); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b expected 1", in_ready); else passed++;
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_single_push();
    rec_t r;
    r = rand_rec();
    r.pc = 64'h8000_0000; r.insn = 32'h0000_0013;
    clear_inputs();
    set_slot(0, r);
    out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL single_no_bypass: got %0b expected 0", out_valid); else passed++;
    tick();
    clear_inputs();
    #1;
    total++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %0b expected 1", out_valid); else passed++;
    total++; if (dut_head() !== r) $display("FAIL single_head: got %h expected %h", dut_head(), r); else passed++;
    total++; if (occupancy !== 5'd1) $display("FAIL single_occ1: got %0d expected 1", occupancy); else passed++;
    tick();
    total++; if (occupancy !== 5'd0) $display("FAIL single_occ0: got %0d expected 0", occupancy); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL single_drained: got %0b expected 0", out_valid); else passed++;
  endtask

  task automatic test_order();
    logic [63:0] exp_pc [3];
    rec_t r;
    exp_pc[0] = 64'h8000_0004; exp_pc[1] = 64'h8000_0008; exp_pc[2] = 64'h8000_000C;
    out_ready = 1'b0;
    clear_inputs();
    r = rand_rec(); r.pc = exp_pc[0]; set_slot(1, r);
    tick();
    clear_inputs();
    r = rand_rec(); r.pc = exp_pc[1]; set_slot(0, r);
    r = rand_rec(); r.pc = exp_pc[2]; set_slot(1, r);
    tick();
    clear_inputs();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (out_pc !== exp_pc[i]) $display("FAIL order_pc%0d: got %h expected %h", i, out_pc, exp_pc[i]); else passed++;
      total++; if (dut_head() !== mq[0]) $display("FAIL order_rec%0d: got %h expected %h", i, dut_head(), mq[0]); else passed++;
      tick();
    end
    total++; if (out_valid !== 1'b0) $display("FAIL order_empty: got %0b expected 0", out_valid); else passed++;
  endtask

  task automatic test_full_overflow();
    rec_t first, r;
    apply_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      clear_inputs();
      r = rand_rec(); if (c == 0) first = r; set_slot(0, r);
      r = rand_rec(); set_slot(1, r);
      tick();
    end
    clear_inputs();
    #1;
    total++; if (occupancy !== 5'd16) $display("FAIL full_occ: got %0d expected 16", occupancy); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %0b expected 0", in_ready); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL full_no_ovf: got %0b expected 0", overflow); else passed++;
    set_slot(0, rand_rec());
    set_slot(1, rand_rec());
    tick();
    clear_inputs();
    #1;
    total++; if (overflow !== 1'b1) $display("FAIL full_ovf: got %0b expected 1", overflow); else passed++;
    total++; if (occupancy !== 5'd16) $display("FAIL full_occ_after: got %0d expected 16", occupancy); else passed++;
    total++; if (dut_head() !== first) $display("FAIL full_head: got %h expected %h", dut_head(), first); else passed++;
  endtask

  task automatic test_partial_overflow();
    rec_t a, b;
    logic [63:0] last_pc;
    apply_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      clear_inputs();
      set_slot(0, rand_rec());
      set_slot(1, rand_rec());
      tick();
    end
    clear_inputs();
    set_slot(1, rand_rec());
    tick();
    clear_inputs();
    #1;
    total++; if (occupancy !== 5'd15) $display("FAIL part_occ15: got %0d expected 15", occupancy); else passed++;
    a = rand_rec(); b = rand_rec();
    set_slot(0, a); set_slot(1, b);
    out_ready = 1'b1;
    tick();
    clear_inputs();
    out_ready = 1'b0;
    #1;
    total++; if (overflow !== 1'b1) $display("FAIL part_ovf: got %0b expected 1", overflow); else passed++;
    total++; if (occupancy !== 5'd15) $display("FAIL part_occ_after: got %0d expected 15", occupancy); else passed++;
    out_ready = 1'b1;
    last_pc = '0;
    for (int i = 0; i < 15; i++) begin
      #1;
      total++; if (dut_head() !== mq[0]) $display("FAIL part_drain%0d: got %h expected %h", i, dut_head(), mq[0]); else passed++;
      last_pc = out_pc;
      tick();
    end
    total++; if (last_pc !== a.pc) $display("FAIL part_tail_slot0: got %h expected %h", last_pc, a.pc); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    rec_t r;
    apply_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      clear_inputs();
      set_slot(0, rand_rec());
      set_slot(1, rand_rec());
      tick();
    end
    total++; if (occupancy !== 5'd10) $display("FAIL arst_fill: got %0d expected 10", occupancy); else passed++;
    #2;
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL arst_out_valid: got %0b expected 0", out_valid); else passed++;
    total++; if (occupancy !== 5'd0) $display("FAIL arst_occ: got %0d expected 0", occupancy); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL arst_ovf: got %0b expected 0", overflow); else passed++;
    model_reset();
    clear_inputs();
    r = rand_rec(); r.pc = 64'h100;
    set_slot(0, r);
    #1;
    reset = 1'b1;
    tick();
    clear_inputs();
    #1;
    total++; if (out_valid !== 1'b1) $display("FAIL arst_post_valid: got %0b expected 1", out_valid); else passed++;
    total++; if (out_pc !== 64'h100) $display("FAIL arst_post_pc: got %h expected 100", out_pc); else passed++;
  endtask

  task automatic test_random();
    int free;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      for (int s = 0; s < COMMITS; s++)
        if ($urandom_range(0, 2) != 0) set_slot(s, rand_rec());
      out_ready = (c % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      #1;
      free = DEPTH - mq.size();
      total++; if (out_valid !== (mq.size() != 0)) $display("FAIL rnd_valid c%0d: got %0b expected %0b", c, out_valid, mq.size() != 0); else passed++;
      total++; if (occupancy !== 5'(mq.size())) $display("FAIL rnd_occ c%0d: got %0d expected %0d", c, occupancy, mq.size()); else passed++;
      total++; if (in_ready !== (free >= COMMITS)) $display("FAIL rnd_in_ready c%0d: got %0b expected %0b", c, in_ready, free >= COMMITS); else passed++;
      total++; if (overflow !== m_ovf) $display("FAIL rnd_ovf c%0d: got %0b expected %0b", c, overflow, m_ovf); else passed++;
      total++; if (hang !== m_hang) $display("FAIL rnd_hang c%0d: got %0b expected %0b", c, hang, m_hang); else passed++;
      if (mq.size() != 0) begin
        total++; if (dut_head() !== mq[0]) $display("FAIL rnd_head c%0d: got %h expected %h", c, dut_head(), mq[0]); else passed++;
      end
      tick();
    end
    clear_inputs();
    out_ready = 1'b0;
  endtask

  task automatic test_watchdog();
    apply_reset();
    clear_inputs();
    out_ready = 1'b0;
    for (int c = 0; c < TIMEOUT - 1; c++) tick();
    total++; if (hang !== 1'b0) $display("FAIL wd_idle49: got %0b expected 0", hang); else passed++;
    tick();
    total++; if (hang !== WD_ON) $display("FAIL wd_idle50: got %0b expected %0b", hang, WD_ON); else passed++;
    set_slot(0, rand_rec());
    tick();
    clear_inputs();
    for (int c = 0; c < 3; c++) tick();
    total++; if (hang !== WD_ON) $display("FAIL wd_sticky: got %0b expected %0b", hang, WD_ON); else passed++;
    total++; if (hang !== m_hang) $display("FAIL wd_model: got %0b expected %0b", hang, m_hang); else passed++;
  endtask

  initial begin
    clear_inputs();
    out_ready = 1'b0;
    test_reset();
    test_single_push();
    test_order();
    test_full_overflow();
    test_partial_overflow();
    test_async_reset();
    test_random();
    test_watchdog();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/commit_trace_queue.md
Name: commit_trace_queue

Overview:
Upstream stage of the cosim commit checker. Captures up to COMMITS retirement slots per cycle from the core's commit interface, compacts valid slots in program order, buffers them in a circular FIFO, and presents one commit record per cycle to the checker over a valid/ready handshake. Decouples multi-wide retirement from the single-record-per-call DPI checker; reports overflow and, optionally, hangs.

Parameters:
COMMITS, 2, retirement slots per cycle (1..4)
DEPTH, 16, FIFO entries; power of two, >= 2*COMMITS
TIMEOUT, 100000, cycles without a commit before the hang flag sets (optional feature only)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  COMMITS  per-slot retire valid; slot 0 oldest
in_pc  in  64*COMMITS  retired PC per slot
in_insn  in  32*COMMITS  instruction bits per slot
in_rd_valid  in  COMMITS  slot writes a register
in_rd_fp  in  COMMITS  destination is FP file
in_rd_addr  in  5*COMMITS  destination index
in_rd_data  in  64*COMMITS  written value
in_exc_valid  in  COMMITS  slot raised a trap
in_exc_cause  in  64*COMMITS  trap cause
in_ready  out  1  free entries >= COMMITS
out_valid  out  1  head record valid
out_ready  in  1  checker consumes head
out_pc, out_insn, out_rd_valid, out_rd_fp, out_rd_addr, out_rd_data, out_exc_valid, out_exc_cause  out  as inputs  head record fields
occupancy  out  $clog2(DEPTH)+1  current entry count
overflow  out  1  sticky: record dropped
hang  out  1  sticky watchdog flag (0 when feature compiled out)

Behaviour:
- Reset (async assert, sync release): wr_ptr=rd_ptr=0, occupancy=0, out_valid=0, overflow=0, hang=0; storage contents don't care.
- Push: n = popcount(in_valid). Valid slots need not be contiguous; the k-th set slot (ascending index) is written at wr_ptr+k mod DEPTH. wr_ptr advances by the number actually written.
- Free space for push = DEPTH - occupancy at cycle start; a same-cycle pop does not add space.
- Overflow: if n > free, write the first `free` valid slots in order, drop the rest, set overflow (sticky until reset).
- in_ready = (DEPTH - occupancy) >= COMMITS, combinational from registered occupancy. Core may ignore it; overflow is the only consequence.
- Pop: out_valid = (occupancy != 0); out_* driven combinationally from entry[rd_ptr]. On out_valid && out_ready, rd_ptr+1 mod DEPTH. out_ready with empty queue is ignored.
- No bypass: a record pushed in cycle t is visible on out_* no earlier than cycle t+1. Latency when empty is 1 cycle.
- occupancy_next = occupancy + written - popped; simultaneous push/pop at full or empty is legal and never underflows.
- Pointer arithmetic is $clog2(DEPTH) bits and wraps naturally; occupancy is one bit wider so full (==DEPTH) is distinguishable.
- out_* fields stay stable while out_valid && !out_ready.

Optional Feature:
COMMIT_TRACE_WATCHDOG_EN. Defined: a 32-bit counter increments each cycle with no valid slot and clears on any cycle with n>0. When it reaches TIMEOUT, hang sets sticky and the counter saturates. Undefined: no counter is built and hang is tied to 0.

Decomposition:
- commit_trace_pkg: commit_rec_t struct (pc, insn, rd_valid, rd_fp, rd_addr, rd_data, exc_valid, exc_cause), field-width localparams, REC_W.
- Sub-module commit_slot_compactor: combinational per-slot prefix-popcount offsets and total n. The FIFO stays in the top module.

Test Plan:
- Single push slot0 pc=0x80000000 insn=0x00000013, out_ready=1 -> out_valid in next cycle with same fields; occupancy 1 then 0.
- in_valid=2'b10 (slot1 pc=0x80000004) then 2'b11 (0x80000008, 0x8000000C) -> pops in order 0x80000004, 0x80000008, 0x8000000C.
- out_ready=0, push 2 per cycle for 8 cycles -> occupancy 16, in_ready=0, overflow=0. Ninth push -> both slots dropped, overflow=1, occupancy stays 16, head remains first record.
- At occupancy 15, push 2 with pop -> first slot written, second dropped, overflow=1, occupancy 15.
- Fill 10, assert reset low mid-burst -> out_valid=0, occupancy=0, overflow=0 immediately (async). Post-release push pc=0x100 is the first record out.
- With COMMIT_TRACE_WATCHDOG_EN and TIMEOUT=50: idle 49 cycles -> hang=0. Idle 50 -> hang=1 and stays set after a later commit. Without the macro -> hang=0 throughout.
